// File: rtl/wait_time_calc.sv
// wait_time_calc: bank-queue customer wait-time estimator.
// W = floor(SERVICE_TIME * (PCount + TCount - 1) / TCount), computed by a
// sequential restoring divider (one quotient bit per clock, MSB first) under
// a start/done handshake. Results wider than WTIME_W saturate to all ones;
// a zero teller count forces all ones and raises div_err.
// Optional feature macro: ZERO_WAIT_EMPTY_EN -- when defined, an empty queue
// (PCount == 0) always shows a wait time of 0.
module wait_time_calc #(
  parameter int PCOUNT_W     = 3,
  parameter int TCOUNT_W     = 2,
  parameter int WTIME_W      = 5,
  parameter int SERVICE_TIME = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PCOUNT_W-1:0] PCount,
  input  logic [TCOUNT_W-1:0] TCount,
  output logic                busy,
  output logic                done,
  output logic [WTIME_W-1:0]  WTimeOut,
  output logic                div_err
);

  // Numerator width covers the largest possible SERVICE_TIME*(P+T-1).
  localparam int NUM_W = $clog2(SERVICE_TIME * ((2**PCOUNT_W - 1) + (2**TCOUNT_W - 1)) + 1);
  localparam int CNT_W = $clog2(NUM_W + 1);
  localparam int REM_W = TCOUNT_W + 1;
  localparam int QX_W  = (NUM_W > WTIME_W) ? NUM_W : WTIME_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_t;

  // Registered state and datapath
  state_t              r_state;
  logic [NUM_W-1:0]    r_num;
  logic [TCOUNT_W-1:0] r_div;
  logic [REM_W-1:0]    r_rem;
  logic [NUM_W-1:0]    r_quo;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [WTIME_W-1:0]  r_wt;
  logic                r_err;
`ifdef ZERO_WAIT_EMPTY_EN
  logic                r_pzero;
  logic                w_pzero_nx;
`endif

  // Next-state values
  state_t              w_state_nx;
  logic [NUM_W-1:0]    w_num_nx;
  logic [TCOUNT_W-1:0] w_div_nx;
  logic [REM_W-1:0]    w_rem_nx;
  logic [NUM_W-1:0]    w_quo_nx;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic                w_busy_nx;
  logic                w_done_nx;
  logic [WTIME_W-1:0]  w_wt_nx;
  logic                w_err_nx;

  // Helpers
  logic [NUM_W:0]      w_sum;
  logic [NUM_W:0]      w_num_full;
  logic [REM_W-1:0]    w_rem_sh;
  logic                w_ge;
  logic [REM_W-1:0]    w_rem_step;
  logic [NUM_W-1:0]    w_quo_step;
  logic [QX_W-1:0]     w_quo_ext;
  logic                w_sat;
  logic [WTIME_W-1:0]  w_result;

  // Numerator SERVICE_TIME*(PCount+TCount-1) at NUM_W+1 bits, clamped at 0
  // when both counts are zero (the -1 would otherwise wrap).
  always_comb begin
    w_sum = (NUM_W+1)'(PCount) + (NUM_W+1)'(TCount);
    if (w_sum == (NUM_W+1)'(0)) begin
      w_num_full = '0;
    end else begin
      w_num_full = (NUM_W+1)'(SERVICE_TIME) * (w_sum - (NUM_W+1)'(1));
    end
  end

  // One restoring-division step plus result formatting for the final step
  always_comb begin
    w_rem_sh   = {r_rem[TCOUNT_W-1:0], r_num[NUM_W-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_div});
    if (w_ge) begin
      w_rem_step = w_rem_sh - {1'b0, r_div};
    end else begin
      w_rem_step = w_rem_sh;
    end
    w_quo_step = (r_quo << 1) | NUM_W'(w_ge);
    w_quo_ext  = QX_W'(w_quo_step);
    w_sat      = (w_quo_ext > QX_W'({WTIME_W{1'b1}}));
`ifdef ZERO_WAIT_EMPTY_EN
    if (r_pzero) begin
      w_result = '0;
    end else
`endif
    if (r_div == TCOUNT_W'(0)) begin
      w_result = {WTIME_W{1'b1}};
    end else if (w_sat) begin
      w_result = {WTIME_W{1'b1}};
    end else begin
      w_result = WTIME_W'(w_quo_ext);
    end
  end

  // FSM next-state and datapath next values; everything holds by default
  always_comb begin
    w_state_nx = r_state;
    w_num_nx   = r_num;
    w_div_nx   = r_div;
    w_rem_nx   = r_rem;
    w_quo_nx   = r_quo;
    w_cnt_nx   = r_cnt;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_wt_nx    = r_wt;
    w_err_nx   = r_err;
`ifdef ZERO_WAIT_EMPTY_EN
    w_pzero_nx = r_pzero;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_num_nx   = w_num_full[NUM_W-1:0];
          w_div_nx   = TCount;
          w_rem_nx   = '0;
          w_quo_nx   = '0;
          w_cnt_nx   = CNT_W'(NUM_W);
          w_busy_nx  = 1'b1;
          w_state_nx = ST_DIV;
`ifdef ZERO_WAIT_EMPTY_EN
          w_pzero_nx = (PCount == PCOUNT_W'(0));
`endif
        end else begin
          w_busy_nx  = 1'b0;
        end
      end
      ST_DIV: begin
        w_num_nx = r_num << 1;
        w_rem_nx = w_rem_step;
        w_quo_nx = w_quo_step;
        w_cnt_nx = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_wt_nx    = w_result;
          w_err_nx   = (r_div == TCOUNT_W'(0));
          w_done_nx  = 1'b1;
          w_busy_nx  = 1'b0;
          w_state_nx = ST_IDLE;
        end else begin
          w_busy_nx  = 1'b1;
        end
      end
      default: begin
        w_busy_nx  = 1'b0;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset aborts any computation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_num   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wt    <= '0;
      r_err   <= 1'b0;
`ifdef ZERO_WAIT_EMPTY_EN
      r_pzero <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_num   <= w_num_nx;
      r_div   <= w_div_nx;
      r_rem   <= w_rem_nx;
      r_quo   <= w_quo_nx;
      r_cnt   <= w_cnt_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_wt    <= w_wt_nx;
      r_err   <= w_err_nx;
`ifdef ZERO_WAIT_EMPTY_EN
      r_pzero <= w_pzero_nx;
`endif
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign WTimeOut = r_wt;
  assign div_err  = r_err;

endmodule
